// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs UART symbols into words and queues them in a FWFT FIFO
//
// Purpose: gathers INPUT_SIZE-bit symbols into OUTPUT_SIZE-bit words (symbol order set by
// MSB_FIRST), closes partial words on flush (zero-padded), queues finished words in a
// FIFO_DEPTH-entry first-word-fall-through FIFO and reports dropped words with a sticky flag.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   data_in, write    symbol and its strobe (never back-pressured)
//   flush             close the current partial word
//   clear_ovf         clear the sticky overflow flag
//   data_out          FIFO head word (0 when empty)
//   data_partial      head word came from a flush
//   output_valid      FIFO non-empty
//   output_ready      consumer accepts the head word
//   fifo_count        words held in the FIFO
//   overflow          sticky: a completed word was dropped
module uart_word_packer #(
  parameter int OUTPUT_SIZE = 16,
  parameter int INPUT_SIZE  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INPUT_SIZE-1:0]         data_in,
  input  logic                          write,
  input  logic                          flush,
  input  logic                          clear_ovf,
  output logic [OUTPUT_SIZE-1:0]        data_out,
  output logic                          data_partial,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int N  = OUTPUT_SIZE / INPUT_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int KW = PW + 1;

  if (OUTPUT_SIZE % INPUT_SIZE != 0) begin : g_bad_ratio
    $error("OUTPUT_SIZE must be an integer multiple of INPUT_SIZE");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [CW-1:0]          sym_cnt;
  logic [OUTPUT_SIZE-1:0] acc;
  logic [OUTPUT_SIZE-1:0] word_next;
  logic                   last_sym;
  logic                   close;
  logic                   pop;
  logic                   accept;
  int                     shamt;

  // Entry layout: {partial, word}
  logic [OUTPUT_SIZE:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [KW-1:0]          count;

  // Every slot of the accumulator is zero until written once per word, so
  // inserting a symbol is a plain OR of the shifted symbol.
  always_comb begin
    shamt     = MSB_FIRST ? (N - 1 - int'(sym_cnt)) * INPUT_SIZE : int'(sym_cnt) * INPUT_SIZE;
    word_next = acc;
    if (write) begin
      word_next = acc | (OUTPUT_SIZE'(data_in) << shamt);
    end
  end

  assign last_sym     = (sym_cnt == CW'(N - 1));
  // A flush with nothing stored and no symbol arriving must not push an empty word.
  assign close        = (write && last_sym) || (flush && (write || sym_cnt != '0));
  assign output_valid = (count != '0);
  assign pop          = output_valid && output_ready;
  // A pop in the same cycle frees the slot even when the FIFO is full.
  assign accept       = close && ((count < KW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_cnt  <= '0;
      acc      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (close) begin
        sym_cnt <= '0;
        acc     <= '0;
      end else if (write) begin
        sym_cnt <= sym_cnt + 1'b1;
        acc     <= word_next;
      end

      if (accept) begin
        mem[wr_ptr] <= {!(write && last_sym), word_next};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (close && !accept) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign data_out     = output_valid ? mem[rd_ptr][OUTPUT_SIZE-1:0] : '0;
  assign data_partial = output_valid ? mem[rd_ptr][OUTPUT_SIZE] : 1'b0;
  assign fifo_count   = count;

endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - randomized and directed checks of uart_word_packer against a queue model
module tb_uart_word_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, write, flush, clear_ovf, output_ready;
  logic [3:0]  data_in;
  logic [15:0] dout_m, dout_l;
  logic        part_m, part_l, val_m, val_l, ovf_m, ovf_l;
  logic [2:0]  cnt_m, cnt_l;

  uart_word_packer #(.OUTPUT_SIZE(16), .INPUT_SIZE(4), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .write(write), .flush(flush),
    .clear_ovf(clear_ovf), .data_out(dout_m), .data_partial(part_m), .output_valid(val_m),
    .output_ready(output_ready), .fifo_count(cnt_m), .overflow(ovf_m));

  uart_word_packer #(.OUTPUT_SIZE(16), .INPUT_SIZE(4), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .write(write), .flush(flush),
    .clear_ovf(clear_ovf), .data_out(dout_l), .data_partial(part_l), .output_valid(val_l),
    .output_ready(output_ready), .fifo_count(cnt_l), .overflow(ovf_l));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: symbols of the open word, queue of finished words.
  typedef struct {
    logic [15:0] wm;
    logic [15:0] wl;
    logic        p;
  } ent_t;

  ent_t       q[$];
  logic [3:0] syms[$];
  logic       m_ovf = 1'b0;

  task automatic model_step(input logic w, input logic [3:0] d, input logic f,
                            input logic c, input logic r, input logic rs);
    bit   pop, full, close, drop;
    ent_t e;
    if (rs) begin
      q.delete();
      syms.delete();
      m_ovf = 1'b0;
      return;
    end
    pop  = r && (q.size() > 0);
    drop = 0;
    if (w) syms.push_back(d);
    full  = (syms.size() == 4);
    close = full || (f && syms.size() > 0);
    if (pop) void'(q.pop_front());
    if (close) begin
      e.wm = 16'h0;
      e.wl = 16'h0;
      for (int k = 0; k < syms.size(); k++) begin
        e.wm = e.wm | (16'(syms[k]) << (12 - 4 * k));
        e.wl = e.wl | (16'(syms[k]) << (4 * k));
      end
      e.p = !full;
      if (q.size() < 4) q.push_back(e);
      else drop = 1;
      syms.delete();
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    logic [15:0] ewm, ewl;
    logic        ep, ev;
    logic [2:0]  ec;
    ev  = (q.size() > 0);
    ewm = ev ? q[0].wm : 16'h0;
    ewl = ev ? q[0].wl : 16'h0;
    ep  = ev ? q[0].p : 1'b0;
    ec  = 3'(q.size());
    check("m_data_out", dout_m, ewm);
    check("l_data_out", dout_l, ewl);
    check("m_valid", val_m, ev);
    check("m_partial", part_m, ep);
    check("m_count", cnt_m, ec);
    check("m_overflow", ovf_m, m_ovf);
    check("l_ctl", {val_l, part_l, cnt_l, ovf_l}, {ev, ep, ec, m_ovf});
  endtask

  task automatic cycle(input logic w, input logic [3:0] d, input logic f,
                       input logic c, input logic r, input logic rs);
    write = w; data_in = d; flush = f; clear_ovf = c; output_ready = r; reset = rs;
    @(posedge clk);
    model_step(w, d, f, c, r, rs);
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [3:0] d, input logic r);
    cycle(1'b1, d, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic rst();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    write = 0; data_in = 0; flush = 0; clear_ovf = 0; output_ready = 0; reset = 1;
    rst();
    rst();
    check("rst_data_out", dout_m, 16'h0);
    check("rst_count", cnt_m, 3'd0);

    // Basic MSB-first word
    wr(4'hA, 0); wr(4'hB, 0); wr(4'hC, 0); wr(4'hD, 0);
    check("t1_word", dout_m, 16'hABCD);
    check("t1_valid", val_m, 1'b1);
    check("t1_partial", part_m, 1'b0);
    check("t1_count", cnt_m, 3'd1);

    // LSB-first order
    rst();
    wr(4'h1, 0); wr(4'h2, 0); wr(4'h3, 0); wr(4'h4, 0);
    check("t2_lsb_word", dout_l, 16'h4321);

    // Flush of a partial word, then a flush with nothing stored
    rst();
    wr(4'h7, 0); wr(4'h8, 0);
    cycle(0, 4'h0, 1, 0, 0, 0);
    check("t3_word", dout_m, 16'h7800);
    check("t3_partial", part_m, 1'b1);
    cycle(0, 4'h0, 1, 0, 0, 0);
    check("t3_empty_flush", cnt_m, 3'd1);

    // Overflow with a full FIFO, clear, then drain in order
    rst();
    for (int i = 0; i < 20; i++) wr(4'($urandom), 0);
    check("t4_count", cnt_m, 3'd4);
    check("t4_overflow", ovf_m, 1'b1);
    cycle(0, 4'h0, 0, 1, 0, 0);
    check("t4_cleared", ovf_m, 1'b0);
    for (int i = 0; i < 4; i++) cycle(0, 4'h0, 0, 0, 1, 0);
    check("t4_drained", val_m, 1'b0);

    // Full FIFO with simultaneous pop: no drop
    rst();
    for (int i = 0; i < 19; i++) wr(4'($urandom), 0);
    wr(4'($urandom), 1);
    check("t5_overflow", ovf_m, 1'b0);
    check("t5_count", cnt_m, 3'd4);

    // Reset mid-word leaves no residue
    rst();
    wr(4'hF, 0); wr(4'hE, 0); wr(4'h9, 0);
    rst();
    check("t6_rst_data", dout_m, 16'h0);
    check("t6_rst_valid", val_m, 1'b0);
    wr(4'h1, 0); wr(4'h2, 0); wr(4'h3, 0); wr(4'h4, 0);
    check("t6_word", dout_m, 16'h1234);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
